// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the MIPS MEM-stage load/store port.
// The responder handles one word request at a time. It waits LATENCY cycles, commits the
// access, and then returns a single-cycle response strobe.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject addresses that are not word aligned.
// Memory contents are not reset. Power-up contents are taken to be zero by the memory macro
// or the initialisation of the target.
module dmem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_commit;
    logic          w_in_range;
    logic          w_err;
    logic [AW-1:0] w_idx;

    // The responder can take a new request in both IDLE and RESP. This lets a pipelined
    // request follow in the response cycle.
    assign w_accept   = req_valid && (r_state != StWait);
    assign w_commit   = (r_state == StWait) && (r_cnt == 4'd0);
    assign w_in_range = {2'b00, r_addr[31:2]} < DEPTH;
    assign w_idx      = r_addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_err = !w_in_range || (r_addr[1:0] != 2'b00);
`else
    // Byte-offset bits are ignored; the access always targets word addr >> 2.
    logic w_unused_addr_lo;
    assign w_unused_addr_lo = ^r_addr[1:0];
    assign w_err            = !w_in_range;
`endif

    // Every output is decoded from the state register or taken from a register.
    assign req_ready = (r_state != StWait);
    assign busy      = (r_state == StWait);
    assign rsp_valid = (r_state == StResp);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                w_state_next = w_accept ? StWait : StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Latch the request on accept, and count the wait cycles down toward commit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_cnt   <= CNT_INIT;
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end else if ((r_state == StWait) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Capture the response at commit; it holds until the next commit or reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_err;
            r_rdata <= (r_we || w_err) ? 32'd0 : r_mem[w_idx];
        end
    end

    // Store commit. Reset forces IDLE, so an aborted store never reaches this write.
    always_ff @(posedge clock) begin
        if (w_commit && r_we && !w_err) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder, with DEPTH = 1024 and LATENCY = 2.
module tb_dmem_responder;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_checks;
    int n_errors;

    dmem_responder #(
        .DEPTH   (1024),
        .LATENCY (2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one request and wait for its response.
    // lat counts rising edges, starting with the accept edge as 1.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output int busy_cnt, output int nready_cnt,
                          output logic [31:0] rdata, output logic err);
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        lat        = 1;
        busy_cnt   = 0;
        nready_cnt = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cnt++;
            if (req_ready === 1'b0) nready_cnt++;
            @(posedge clock);
            #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    task automatic test_reset_initial();
        reset_n   = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, busy, rsp_valid, rsp_err} !== 4'b1000) begin
            n_errors++;
            $display("FAIL init_reset_flags: got ready/busy/valid/err=%b required 1000",
                     {req_ready, busy, rsp_valid, rsp_err});
        end
        n_checks++;
        if (rsp_rdata !== 32'd0) begin
            n_errors++;
            $display("FAIL init_reset_rdata: got %h required 0", rsp_rdata);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_store_load();
        int lat, bc, nr;
        logic [31:0] rd;
        logic er;
        do_req(1'b1, 32'h0c, 32'hdeadbeef, lat, bc, nr, rd, er);
        n_checks++;
        if (lat !== 3) begin
            n_errors++;
            $display("FAIL store_latency: got %0d required 3", lat);
        end
        n_checks++;
        if (bc !== 2 || nr !== 2) begin
            n_errors++;
            $display("FAIL store_busy_cycles: got busy=%0d not_ready=%0d required 2/2", bc, nr);
        end
        n_checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            n_errors++;
            $display("FAIL store_rsp: got rdata=%h err=%b required 0/0", rd, er);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rsp_one_cycle: got valid=%b busy=%b ready=%b required 0/0/1",
                     rsp_valid, busy, req_ready);
        end
        do_req(1'b0, 32'h0c, 32'd0, lat, bc, nr, rd, er);
        n_checks++;
        if (lat !== 3 || rd !== 32'hdeadbeef || er !== 1'b0) begin
            n_errors++;
            $display("FAIL load_after_store: got lat=%0d rdata=%h err=%b required 3/deadbeef/0",
                     lat, rd, er);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (rsp_rdata !== 32'hdeadbeef || rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rdata_hold: got rdata=%h valid=%b required deadbeef/0",
                     rsp_rdata, rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, nr, k;
        logic [31:0] rd;
        logic er;
        do_req(1'b1, 32'h10, 32'ha5a5a5a5, lat, bc, nr, rd, er);
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_wdata = 32'd0;
        @(posedge clock);
        #1;
        req_we    = 1'b1;
        req_addr  = 32'h14;
        req_wdata = 32'h5;
        k = 1;
        while (rsp_valid !== 1'b1 && k < 20) begin
            @(posedge clock);
            #1;
            k++;
        end
        n_checks++;
        if (k !== 3 || rsp_rdata !== 32'ha5a5a5a5 || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_first: got lat=%0d rdata=%h ready=%b required 3/a5a5a5a5/1",
                     k, rsp_rdata, req_ready);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_accept_in_resp: got busy=%b required 1", busy);
        end
        k = 1;
        while (rsp_valid !== 1'b1 && k < 20) begin
            @(posedge clock);
            #1;
            k++;
        end
        n_checks++;
        if (k !== 3 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_second: got spacing=%0d rdata=%h err=%b required 3/0/0",
                     k, rsp_rdata, rsp_err);
        end
        do_req(1'b0, 32'h14, 32'd0, lat, bc, nr, rd, er);
        n_checks++;
        if (rd !== 32'h5 || er !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_readback: got rdata=%h err=%b required 5/0", rd, er);
        end
    endtask

    task automatic test_out_of_range();
        int lat, bc, nr;
        logic [31:0] rd;
        logic er;
        do_req(1'b1, 32'h0, 32'h11, lat, bc, nr, rd, er);
        do_req(1'b1, 32'h1000, 32'hffffffff, lat, bc, nr, rd, er);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat !== 3) begin
            n_errors++;
            $display("FAIL oor_store: got err=%b rdata=%h lat=%0d required 1/0/3", er, rd, lat);
        end
        do_req(1'b0, 32'h0, 32'd0, lat, bc, nr, rd, er);
        n_checks++;
        if (rd !== 32'h11 || er !== 1'b0) begin
            n_errors++;
            $display("FAIL oor_no_write: got rdata=%h err=%b required 11/0", rd, er);
        end
        do_req(1'b1, 32'hffc, 32'hcafe, lat, bc, nr, rd, er);
        do_req(1'b0, 32'hffc, 32'd0, lat, bc, nr, rd, er);
        n_checks++;
        if (rd !== 32'hcafe || er !== 1'b0) begin
            n_errors++;
            $display("FAIL last_word: got rdata=%h err=%b required cafe/0", rd, er);
        end
        do_req(1'b0, 32'h1000, 32'd0, lat, bc, nr, rd, er);
        n_checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            n_errors++;
            $display("FAIL oor_load: got rdata=%h err=%b required 0/1", rd, er);
        end
    endtask

    // The response register holds err=1 at this point, so the reset must clear it.
    task automatic test_reset();
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, busy, rsp_valid, rsp_err} !== 4'b1000 || rsp_rdata !== 32'd0) begin
            n_errors++;
            $display("FAIL async_reset: got ready/busy/valid/err=%b rdata=%h required 1000/0",
                     {req_ready, busy, rsp_valid, rsp_err}, rsp_rdata);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_misaligned();
        int lat, bc, nr;
        logic [31:0] rd;
        logic er;
        do_req(1'b1, 32'h0d, 32'h77, lat, bc, nr, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
        n_checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            n_errors++;
            $display("FAIL misaligned_store: got err=%b rdata=%h required 1/0", er, rd);
        end
        do_req(1'b0, 32'h0c, 32'd0, lat, bc, nr, rd, er);
        n_checks++;
        if (rd !== 32'hdeadbeef || er !== 1'b0) begin
            n_errors++;
            $display("FAIL misaligned_word3: got rdata=%h err=%b required deadbeef/0", rd, er);
        end
`else
        n_checks++;
        if (er !== 1'b0 || rd !== 32'd0) begin
            n_errors++;
            $display("FAIL misaligned_store: got err=%b rdata=%h required 0/0", er, rd);
        end
        do_req(1'b0, 32'h0c, 32'd0, lat, bc, nr, rd, er);
        n_checks++;
        if (rd !== 32'h77 || er !== 1'b0) begin
            n_errors++;
            $display("FAIL misaligned_word3: got rdata=%h err=%b required 77/0", rd, er);
        end
`endif
    endtask

    task automatic test_reset_mid_store();
        int lat, bc, nr, seen;
        logic [31:0] rd;
        logic er;
        do_req(1'b1, 32'h20, 32'h0, lat, bc, nr, rd, er);
        do_req(1'b0, 32'h0, 32'd0, lat, bc, nr, rd, er);
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1234;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_store_in_wait: got busy=%b required 1", busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, busy, rsp_valid, rsp_err} !== 4'b1000 || rsp_rdata !== 32'd0) begin
            n_errors++;
            $display("FAIL mid_store_reset: got ready/busy/valid/err=%b rdata=%h required 1000/0",
                     {req_ready, busy, rsp_valid, rsp_err}, rsp_rdata);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            if (rsp_valid === 1'b1) seen++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            if (rsp_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++;
            $display("FAIL aborted_rsp: got %0d rsp_valid cycles required 0", seen);
        end
        do_req(1'b0, 32'h20, 32'd0, lat, bc, nr, rd, er);
        n_checks++;
        if (rd !== 32'd0 || er !== 1'b0 || lat !== 3) begin
            n_errors++;
            $display("FAIL aborted_no_write: got rdata=%h err=%b lat=%0d required 0/0/3",
                     rd, er, lat);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset_initial();
        test_store_load();
        test_back_to_back();
        test_out_of_range();
        test_reset();
        test_misaligned();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS pipeline: the memory-side end of the MEM-stage load/store interface. It accepts one word request at a time over a valid/ready handshake and models a configurable access latency. Loads return read data and stores return an acknowledge. The pipeline holds its MEM stage while `busy` is high.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words; word index is `req_addr >> 2`.
- `LATENCY`, 2: wait cycles between accept and memory commit; legal range 1–15.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_we`  in  1  1 = store (SW), 0 = load (LW).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  32  load data; 0 for stores and errors.
- `rsp_err`  out  1  request rejected; qualified by `rsp_valid`.
- `busy`  out  1  stall to the pipeline MEM stage.

## Operation
- States: IDLE, WAIT, RESP.
- `req_ready` = 1 in IDLE and RESP; 0 in WAIT.
- `busy` = 1 exactly in WAIT.
- Accept occurs when `req_valid & req_ready` is true at a rising edge.
  - On accept, latch `req_we`, `req_addr` and `req_wdata`, load the wait counter with `LATENCY-1`, and go to WAIT.
  - Inputs are ignored when no accept occurs.
- WAIT:
  - Decrement the counter each cycle.
  - On the edge where the counter is 0, commit the access and go to RESP.
  - Load commit: read the word into the response register.
  - Store commit: write the word.
- Error check, evaluated at commit:
  - Word index ≥ `DEPTH` is an error: no write, `rsp_rdata` = 0, `rsp_err` = 1.
- RESP:
  - `rsp_valid` = 1 for exactly one cycle, with `rsp_rdata` and `rsp_err` valid.
  - If a request is accepted in the same cycle, next state is WAIT; otherwise IDLE.
- Read-after-write: a load accepted after a store's RESP cycle sees the stored value. Only one request is ever in flight.
- Memory contents are not affected by reset and are zero at time 0.
- Reset mid-operation aborts the request. A store not yet committed is never written.
- Reset values: `req_ready` = 1, `busy` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, state IDLE, counter 0.
- `rsp_rdata` and `rsp_err` hold their last values outside RESP. They return to 0 only on reset.

## Timing
- Accept at edge n → WAIT in cycles n+1 … n+LATENCY → RESP (`rsp_valid` high) in cycle n+LATENCY+1.
- Request-to-response latency is LATENCY+1 cycles.
- Sustained throughput, with the next request accepted in RESP: one request per LATENCY+1 cycles.
- All outputs are registered or decoded from the state register only. There is no combinational path from request inputs to any output.
- `reset_n` low forces reset values immediately, without waiting for a clock edge. Leaving reset takes effect on the first rising edge after `reset_n` goes high.

## Configuration
- `DMEM_ALIGN_CHECK_EN`
  - Defined: `req_addr[1:0] != 0` is an error, with the same response as out-of-range (no write, `rsp_err` = 1, `rsp_rdata` = 0).
  - Undefined: `req_addr[1:0]` is ignored; the access uses word `req_addr >> 2` and `rsp_err` flags only out-of-range.

## Test plan
- Reset: drive `reset_n` = 0 mid-simulation → `req_ready` = 1, `busy` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, all asynchronously.
- Store then load, LATENCY = 2:
  - Store 32'hdeadbeef to 0x0c → `rsp_valid` exactly 3 cycles after accept, `rsp_rdata` = 0, `rsp_err` = 0, `busy` high 2 cycles.
  - Then load 0x0c → `rsp_rdata` = 32'hdeadbeef.
- Back-to-back: hold `req_valid` with load 0x10 then store 0x14 = 32'h5 → second accept occurs in the first RESP cycle; responses are 3 cycles apart; a following load of 0x14 returns 32'h5.
- Out of range, DEPTH = 1024: store to 0x1000 → `rsp_err` = 1, `rsp_rdata` = 0, and a load of 0x0 still returns the prior value.
- Misaligned address 0x0d with data 32'h77:
  - With `DMEM_ALIGN_CHECK_EN`: `rsp_err` = 1 and word 3 is unchanged.
  - Without: `rsp_err` = 0 and word 3 = 32'h77.
- Reset mid-store: store 32'h1234 to 0x20 (word previously 0), assert `reset_n` low during WAIT, release → load 0x20 returns 0 and no `rsp_valid` is seen for the aborted store.
